dpd_pack_stream: RTL and testbench
==================================

DPD_PACK_STREAM -- requirements
Module: dpd_pack_stream

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: in_digit/in_last are valid.
REQ-004 SHALL have port in_digit, input, 4 bits: one BCD digit, most-significant digit of each triplet first.
REQ-005 SHALL have port in_last, input, 1 bit: the accepted digit closes the current group.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a digit this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: out_dpd/out_last/out_err are valid.
REQ-008 SHALL have port out_dpd, output, 10 bits: packed declet, bit 9 = p, bit 0 = y.
REQ-009 SHALL have port out_last, output, 1 bit: declet closes a group.
REQ-010 SHALL have port out_err, output, 1 bit: declet contains a non-BCD digit.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the declet.

Function
REQ-012 SHALL transfer an input digit only on a cycle with in_valid=1 and in_ready=1, and an output declet only on a cycle with out_valid=1 and out_ready=1.
REQ-013 SHALL keep a digit counter in states S0, S1, S2 (0, 1 or 2 digits held); an accepted digit advances S0->S1->S2->S0; an accepted digit with in_last=1 returns to S0 from any state.
REQ-014 SHALL complete a triplet on the third accepted digit, or on any accepted digit with in_last=1; missing lower digits of a short group are padded as 0 (e.g. "4",last = digits 4,0,0).
REQ-015 SHALL load the completed triplet's encoding into a single output register, asserting out_valid on the next cycle (latency 1 cycle from the completing handshake).
REQ-016 SHALL drive in_ready=0 only while a completing digit cannot be stored, i.e. out_valid=1 and out_ready=0; otherwise in_ready=1 (non-completing digits are always accepted).
REQ-017 SHALL sustain one digit per cycle when out_ready=1; an output drain and a new load in the same cycle SHALL keep out_valid=1 with the new declet.
REQ-018 SHALL hold out_dpd, out_last, out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL encode digits D2=abcd, D1=efgh, D0=ijkm (a, e, i = MSBs) per IEEE 754-2008 DPD by aei: 000 -> bcd fgh 0 jkm; 001 -> bcd fgh 100m; 010 -> bcd jkh 101m; 100 -> jkd fgh 110m; 110 -> jkd 00h 111m; 101 -> fgd 01h 111m; 011 -> bcd 10h 111m; 111 -> 00d 11h 111m.
REQ-020 SHALL set out_last to the in_last of the completing digit.

Reset
REQ-021 SHALL, while rst_n=0, force state S0, clear held digits, and drive out_valid=0, out_dpd=0, out_last=0, out_err=0; in_ready=1 from the first cycle after release.
REQ-022 SHALL discard any partial triplet and any undelivered declet when reset asserts mid-operation; no output results from digits accepted before reset.

Configuration
REQ-023 SHALL, with macro DPD_PACK_CHECK_EN defined, set out_err=1 for a declet if any of its three digits (padding excluded) was 10..15, with encoding still per REQ-019 on the raw bits.
REQ-024 SHALL, without DPD_PACK_CHECK_EN, tie out_err to 0 and contain no digit-range checking logic; encoding unchanged.

Verification
REQ-025 SHALL cover: digits 1,2,3 (in_last on 3), out_ready=1 -> out_dpd=0x0A3, out_last=1, out_valid one cycle after the digit 3 handshake.
REQ-026 SHALL cover: triplets 9,9,9 / 0,0,8 / 0,8,0 / 8,0,0 -> 0x0FF, 0x008, 0x00A, 0x00C in order, back-to-back at one digit per cycle.
REQ-027 SHALL cover: out_ready=0 with declet pending, two further digits then a completing third -> first two accepted, in_ready=0 on the third until out_ready=1, pending declet held stable throughout.
REQ-028 SHALL cover: digit 5 with in_last=1 from S0 -> out_dpd=0x280 (digits 5,0,0), out_last=1; digits 0,5 with in_last on 5 -> 0x050.
REQ-029 SHALL cover: rst_n pulsed low after two accepted digits -> no declet emitted; next triplet 0,0,5 -> 0x005.
REQ-030 SHALL cover: digits 1,12,3 -> out_err=1 with DPD_PACK_CHECK_EN defined, out_err=0 without it.

Source files
------------

// File: rtl/dpd_pack_stream.sv
// Streams BCD digits in, groups them into triplets and emits IEEE 754-2008 densely packed declets.
// Optional digit-range flagging is enabled by defining DPD_PACK_CHECK_EN.
module dpd_pack_stream (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [9:0] out_dpd,
    output logic       out_last,
    output logic       out_err,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] d2_r;
    logic [3:0] d1_r;
    logic       closes_s;
    logic       in_ready_s;
    logic       accept_s;
    logic       load_s;
    logic [3:0] t2_s;
    logic [3:0] t1_s;
    logic [3:0] t0_s;
    logic [9:0] dpd_s;
    logic       err_s;
    logic       out_valid_r;
    logic [9:0] out_dpd_r;
    logic       out_last_r;
    logic       out_err_r;

    // Encodes hi/mid/lo digits (abcd/efgh/ijkm) into pqrstuvwxy, selected by the MSBs a, e, i.
    function automatic logic [9:0] dpd_encode(input logic [3:0] hi, input logic [3:0] mid,
                                              input logic [3:0] lo);
        logic [9:0] r;
        case ({hi[3], mid[3], lo[3]})
            3'b000:  r = {hi[2:0], mid[2:0], 1'b0, lo[2:0]};
            3'b001:  r = {hi[2:0], mid[2:0], 3'b100, lo[0]};
            3'b010:  r = {hi[2:0], lo[2:1], mid[0], 3'b101, lo[0]};
            3'b100:  r = {lo[2:1], hi[0], mid[2:0], 3'b110, lo[0]};
            3'b110:  r = {lo[2:1], hi[0], 2'b00, mid[0], 3'b111, lo[0]};
            3'b101:  r = {mid[2:1], hi[0], 2'b01, mid[0], 3'b111, lo[0]};
            3'b011:  r = {hi[2:0], 2'b10, mid[0], 3'b111, lo[0]};
            3'b111:  r = {2'b00, hi[0], 2'b11, mid[0], 3'b111, lo[0]};
            default: r = 10'd0;
        endcase
        return r;
    endfunction

`ifdef DPD_PACK_CHECK_EN
    // A 4-bit code above 9 has its MSB set together with either middle bit.
    function automatic logic digit_bad(input logic [3:0] dg);
        return dg[3] & (dg[2] | dg[1]);
    endfunction
`endif

    // Handshake: only a completing digit can be blocked, and only by a stalled output register.
    always_comb begin
        closes_s   = (state_r == S2) | in_last;
        in_ready_s = ~(closes_s & out_valid_r & ~out_ready);
        accept_s   = in_valid & in_ready_s;
        load_s     = accept_s & closes_s;
    end

    // Assemble the triplet seen by the encoder; short groups pad the lower digits with zero.
    always_comb begin
        t2_s = 4'd0;
        t1_s = 4'd0;
        t0_s = 4'd0;
        case (state_r)
            S0: begin
                t2_s = in_digit;
            end
            S1: begin
                t2_s = d2_r;
                t1_s = in_digit;
            end
            S2: begin
                t2_s = d2_r;
                t1_s = d1_r;
                t0_s = in_digit;
            end
            default: begin
                t2_s = 4'd0;
            end
        endcase
        dpd_s = dpd_encode(t2_s, t1_s, t0_s);
`ifdef DPD_PACK_CHECK_EN
        err_s = digit_bad(t2_s) | digit_bad(t1_s) | digit_bad(t0_s);
`else
        err_s = 1'b0;
`endif
    end

    // Digit counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Digit counter next state: a group end returns to S0 from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            if (closes_s) begin
                state_nxt_s = S0;
            end else begin
                case (state_r)
                    S0:      state_nxt_s = S1;
                    S1:      state_nxt_s = S2;
                    default: state_nxt_s = S0;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Held upper digits of the triplet in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2_r <= 4'd0;
            d1_r <= 4'd0;
        end else if (accept_s && !closes_s) begin
            case (state_r)
                S0:      d2_r <= in_digit;
                S1:      d1_r <= in_digit;
                default: d2_r <= d2_r;
            endcase
        end else begin
            d2_r <= d2_r;
            d1_r <= d1_r;
        end
    end

    // Single-entry output register; a load in the same cycle as a drain keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_dpd_r   <= 10'd0;
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_dpd_r   <= dpd_s;
            out_last_r  <= in_last;
            out_err_r   <= err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_dpd   = out_dpd_r;
    assign out_last  = out_last_r;
`ifdef DPD_PACK_CHECK_EN
    assign out_err   = out_err_r;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dpd_pack_stream.sv
// Scoreboard bench for dpd_pack_stream: directed triplets with hand-computed declets.
module tb_dpd_pack_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_digit;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_dpd;
    logic       out_last;
    logic       out_err;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    dpd_pack_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_digit (in_digit),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_dpd  (out_dpd),
        .out_last (out_last),
        .out_err  (out_err),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_dpd(input logic [9:0] dpd, input logic lst, input logic err);
        exp_q.push_back({err, lst, dpd});
    endtask

    // Present one digit and hold it until it is accepted (bounded).
    task automatic send(input logic [3:0] dg, input logic lst);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_digit = dg;
        in_last  = lst;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_digit = 4'd0;
        in_last  = 1'b0;
    endtask

    // Monitor: inputs change only just after posedge, so a negedge sample shows the coming transfer.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_declet got %0h expected none", out_dpd);
            end else begin
                e = exp_q.pop_front();
                chk("out_dpd", {22'd0, out_dpd}, {22'd0, e[9:0]});
                chk("out_last", {31'd0, out_last}, {31'd0, e[10]});
                chk("out_err", {31'd0, out_err}, {31'd0, e[11]});
            end
        end
    end

    initial begin
        logic exp_err;
        int n;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_dpd", {22'd0, out_dpd}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 1,2,3 with last: latency of one cycle after the final handshake
        expect_dpd(10'h0A3, 1'b1, 1'b0);
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
        send(4'd3, 1'b1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_dpd", {22'd0, out_dpd}, 32'h0A3);
        idle();
        @(posedge clk);
        #1;

        // Back-to-back triplets at one digit per cycle
        expect_dpd(10'h0FF, 1'b0, 1'b0);
        expect_dpd(10'h008, 1'b0, 1'b0);
        expect_dpd(10'h00A, 1'b0, 1'b0);
        expect_dpd(10'h00C, 1'b1, 1'b0);
        send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0);
        send(4'd0, 1'b0); send(4'd0, 1'b0); send(4'd8, 1'b0);
        send(4'd0, 1'b0); send(4'd8, 1'b0); send(4'd0, 1'b0);
        send(4'd8, 1'b0); send(4'd0, 1'b0); send(4'd0, 1'b1);
        idle();
        @(posedge clk);
        #1;

        // Backpressure: pending declet, two digits accepted, completing third stalls
        out_ready = 1'b0;
        expect_dpd(10'h0A3, 1'b1, 1'b0);
        expect_dpd(10'h256, 1'b0, 1'b0);
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        send(4'd4, 1'b0);
        send(4'd5, 1'b0);
        in_valid = 1'b1;
        in_digit = 4'd6;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_dpd", {22'd0, out_dpd}, 32'h0A3);
            chk("stall_last", {31'd0, out_last}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle();
        chk("drain_load_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_load_dpd", {22'd0, out_dpd}, 32'h256);
        @(posedge clk);
        #1;

        // Short groups padded with zeros
        expect_dpd(10'h280, 1'b1, 1'b0);
        expect_dpd(10'h050, 1'b1, 1'b0);
        send(4'd5, 1'b1);
        send(4'd0, 1'b0);
        send(4'd5, 1'b1);
        idle();
        @(posedge clk);
        #1;

        // Reset mid-group discards the partial triplet
        send(4'd7, 1'b0);
        send(4'd7, 1'b0);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_dpd(10'h005, 1'b1, 1'b0);
        send(4'd0, 1'b0);
        send(4'd0, 1'b0);
        send(4'd5, 1'b1);
        idle();

        // Non-BCD middle digit: encoding on raw bits, error flag only with checking built in
`ifdef DPD_PACK_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        expect_dpd(10'h0AB, 1'b1, exp_err);
        send(4'd1, 1'b0);
        send(4'd12, 1'b0);
        send(4'd3, 1'b1);
        idle();

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
